// File: rtl/hv_similarity_64_pkg.sv
// Shared types for the hypervector similarity search (package hv_pkg).
// HV_SIM_MARGIN_EN (see top) adds a best/second-best margin output.
package hv_pkg;
  localparam int DIST_WIDTH = 7;
  typedef logic [DIST_WIDTH-1:0] dist_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} state_t;
  localparam dist_t DIST_INIT = 7'd127;
endpackage

// File: rtl/hv_similarity_64_popcount.sv
// 64-bit population count as a balanced adder tree, purely combinational.
module popcount_64 (
  input  logic [63:0] i_vec,
  output logic [6:0]  o_count
);
  logic [1:0] w_l1 [32];
  logic [2:0] w_l2 [16];
  logic [3:0] w_l3 [8];
  logic [4:0] w_l4 [4];
  logic [5:0] w_l5 [2];

  for (genvar g = 0; g < 32; g++) begin : g_l1
    assign w_l1[g] = {1'b0, i_vec[2*g]} + {1'b0, i_vec[2*g+1]};
  end
  for (genvar g = 0; g < 16; g++) begin : g_l2
    assign w_l2[g] = {1'b0, w_l1[2*g]} + {1'b0, w_l1[2*g+1]};
  end
  for (genvar g = 0; g < 8; g++) begin : g_l3
    assign w_l3[g] = {1'b0, w_l2[2*g]} + {1'b0, w_l2[2*g+1]};
  end
  for (genvar g = 0; g < 4; g++) begin : g_l4
    assign w_l4[g] = {1'b0, w_l3[2*g]} + {1'b0, w_l3[2*g+1]};
  end
  for (genvar g = 0; g < 2; g++) begin : g_l5
    assign w_l5[g] = {1'b0, w_l4[2*g]} + {1'b0, w_l4[2*g+1]};
  end
  assign o_count = {1'b0, w_l5[0]} + {1'b0, w_l5[1]};
endmodule

// File: rtl/hv_similarity_64.sv
// Binarizes the encoder vector and finds the nearest stored class by Hamming distance.
// Optional HV_SIM_MARGIN_EN: adds 'margin' = second-best minus best distance.
module hv_similarity_64
  import hv_pkg::*;
#(
  parameter int M_SIZE      = 64,
  parameter int DIM_WIDTH   = 16,
  parameter int NUM_CLASSES = 16,
  parameter int THRESH      = 256,
  parameter int CLS_AW      = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [M_SIZE-1:0][DIM_WIDTH-1:0]  enc_in,
  input  logic                              enc_done,
  input  logic                              cls_we,
  input  logic [CLS_AW-1:0]                 cls_waddr,
  input  logic [M_SIZE-1:0]                 cls_wdata,
  output logic                              busy,
  output logic                              result_valid,
  output logic [CLS_AW-1:0]                 class_idx,
  output dist_t                             min_dist,
`ifdef HV_SIM_MARGIN_EN
  output dist_t                             margin,
`endif
  output logic [1:0]                        dbg_state
);
  logic [M_SIZE-1:0] r_bank [NUM_CLASSES];
  state_t            r_state;
  logic              r_enc_done_q;
  logic              r_busy;
  logic              r_result_valid;
  logic [M_SIZE-1:0] r_query;
  logic [CLS_AW-1:0] r_idx;
  logic [CLS_AW-1:0] r_best_idx;
  logic [CLS_AW-1:0] r_class_idx;
  dist_t             r_best_dist;
  dist_t             r_min_dist;
`ifdef HV_SIM_MARGIN_EN
  dist_t             r_second_dist;
  dist_t             r_margin;
`endif

  logic [M_SIZE-1:0] w_query;
  logic [M_SIZE-1:0] w_xor;
  dist_t             w_dist;
  logic              w_trigger;
  logic              w_last;
  logic              w_wr_ok;

  always_comb begin
    w_query = '0;
    for (int i = 0; i < M_SIZE; i++) w_query[i] = (enc_in[i] > DIM_WIDTH'(THRESH));
  end

  // enc_done is a level; only its rising edge (seen while not searching) starts a search.
  assign w_trigger = enc_done & ~r_enc_done_q & ((r_state == IDLE) | (r_state == DONE));
  assign w_last    = (r_idx == CLS_AW'(NUM_CLASSES - 1));
  assign w_wr_ok   = cls_we & ~r_busy & ({1'b0, cls_waddr} < (CLS_AW + 1)'(NUM_CLASSES));
  assign w_xor     = r_query ^ r_bank[r_idx];

  popcount_64 u_popcount (
    .i_vec   (w_xor),
    .o_count (w_dist)
  );

  // Bank is read combinationally, so a write landing on the trigger edge is visible to that search.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_bank[cls_waddr] <= cls_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_enc_done_q   <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_query        <= '0;
      r_idx          <= '0;
      r_best_idx     <= '0;
      r_best_dist    <= DIST_INIT;
      r_class_idx    <= '0;
      r_min_dist     <= '0;
`ifdef HV_SIM_MARGIN_EN
      r_second_dist  <= DIST_INIT;
      r_margin       <= '0;
`endif
    end else begin
      r_enc_done_q <= enc_done;
      case (r_state)
        IDLE, DONE: begin
          if (w_trigger) begin
            r_state        <= SEARCH;
            r_query        <= w_query;
            r_idx          <= '0;
            r_best_idx     <= '0;
            r_best_dist    <= DIST_INIT;
            r_busy         <= 1'b1;
            r_result_valid <= 1'b0;
`ifdef HV_SIM_MARGIN_EN
            r_second_dist  <= DIST_INIT;
`endif
          end else if (r_state == DONE) begin
            r_class_idx    <= r_best_idx;
            r_min_dist     <= r_best_dist;
            r_result_valid <= 1'b1;
`ifdef HV_SIM_MARGIN_EN
            r_margin       <= r_second_dist - r_best_dist;
`endif
          end
        end
        SEARCH: begin
          // Strict compare keeps the lowest index on ties.
          if (w_dist < r_best_dist) begin
            r_best_dist <= w_dist;
            r_best_idx  <= r_idx;
`ifdef HV_SIM_MARGIN_EN
            r_second_dist <= r_best_dist;
          end else if (w_dist < r_second_dist) begin
            r_second_dist <= w_dist;
`endif
          end
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign class_idx    = r_class_idx;
  assign min_dist     = r_min_dist;
`ifdef HV_SIM_MARGIN_EN
  assign margin       = r_margin;
`endif
  assign dbg_state    = r_state;
endmodule

// File: tb/tb_hv_similarity_64.sv
// Self-checking bench for hv_similarity_64: table vectors, hand sequences, random vs. model.
// Margin checks compile in when HV_SIM_MARGIN_EN is defined.
module tb_hv_similarity_64;
  logic               clk = 1'b0;
  logic               reset;
  logic [63:0][15:0]  enc_in;
  logic               enc_done;
  logic               cls_we;
  logic [3:0]         cls_waddr;
  logic [63:0]        cls_wdata;
  logic               busy;
  logic               result_valid;
  logic [3:0]         class_idx;
  logic [6:0]         min_dist;
`ifdef HV_SIM_MARGIN_EN
  logic [6:0]         margin;
`endif
  logic [1:0]         dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_lanes [64];
  logic [63:0] bank_m  [16];

  typedef struct {
    logic [15:0] lane_val;
    int          hot_idx;
    logic [63:0] hot_val;
    logic [63:0] other_val;
    int          exp_idx;
    int          exp_dist;
  } vec_t;
  vec_t tbl [6];

  hv_similarity_64 dut (
    .clk          (clk),
    .reset        (reset),
    .enc_in       (enc_in),
    .enc_done     (enc_done),
    .cls_we       (cls_we),
    .cls_waddr    (cls_waddr),
    .cls_wdata    (cls_wdata),
    .busy         (busy),
    .result_valid (result_valid),
    .class_idx    (class_idx),
    .min_dist     (min_dist),
`ifdef HV_SIM_MARGIN_EN
    .margin       (margin),
`endif
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic write_class(input logic [3:0] a, input logic [63:0] d);
    cls_we = 1'b1; cls_waddr = a; cls_wdata = d;
    @(posedge clk); #1;
    cls_we = 1'b0;
  endtask

  task automatic load_bank();
    for (int c = 0; c < 16; c++) write_class(4'(c), bank_m[c]);
  endtask

  task automatic set_lanes_all(input logic [15:0] v);
    for (int i = 0; i < 64; i++) m_lanes[i] = v;
  endtask

  // Reference: threshold each lane, Hamming distance to every class, pick minimum and runner-up.
  task automatic model(output int bi, output int bd, output int sd);
    logic [63:0] q;
    int d;
    for (int i = 0; i < 64; i++) q[i] = (m_lanes[i] > 16'd256);
    bi = 0; bd = 1000; sd = 1000;
    for (int c = 0; c < 16; c++) begin
      d = $countones(q ^ bank_m[c]);
      if (d < bd) begin bd = d; bi = c; end
    end
    for (int c = 0; c < 16; c++) begin
      d = $countones(q ^ bank_m[c]);
      if (c != bi && d < sd) sd = d;
    end
  endtask

  // Returns #1 after the edge that samples the trigger; optional write rides on that edge.
  task automatic start_search(input logic we, input logic [3:0] a, input logic [63:0] d);
    enc_done = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) enc_in[i] = m_lanes[i];
    enc_done = 1'b1;
    cls_we = we; cls_waddr = a; cls_wdata = d;
    @(posedge clk); #1;
    cls_we = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_idx, input int exp_dist,
                             input int exp_margin, input bit chk_lat);
    int k;
    int busy_cycles;
    k = 0;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    while (result_valid !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (busy === 1'b1 && result_valid !== 1'b1) busy_cycles++;
    end
    if (chk_lat) begin
      check({tag, " latency"}, 64'(k), 64'd17);
      check({tag, " busy_cycles"}, 64'(busy_cycles), 64'd16);
    end
    check({tag, " class_idx"}, 64'(class_idx), 64'(exp_idx));
    check({tag, " min_dist"}, 64'(min_dist), 64'(exp_dist));
`ifdef HV_SIM_MARGIN_EN
    if (exp_margin >= 0) check({tag, " margin"}, 64'(margin), 64'(exp_margin));
`endif
  endtask

  initial begin
    int bi, bd, sd, busy_seen;
    logic [63:0] ones;
    ones = '1;

    tbl[0] = '{16'd300,   5,  ones,          64'h0, 5,  0};
    tbl[1] = '{16'd256,   3,  64'h1,         ones,  3,  1};
    tbl[2] = '{16'd257,   0,  64'h0,         ones,  1,  0};
    tbl[3] = '{16'd0,     15, 64'hFF,        ones,  15, 8};
    tbl[4] = '{16'd65535, 7,  64'hF,         64'h0, 7,  60};
    tbl[5] = '{16'd256,   0,  64'h0,         64'h0, 0,  0};

    // Clock/reset
    reset = 1'b1; enc_done = 1'b0; cls_we = 1'b0; cls_waddr = '0; cls_wdata = '0; enc_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset result_valid", 64'(result_valid), 64'd0);
    check("reset class_idx", 64'(class_idx), 64'd0);
    check("reset min_dist", 64'(min_dist), 64'd0);
    check("reset state", 64'(dbg_state), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // First search from reset, then hold enc_done: no retrigger
    for (int c = 0; c < 16; c++) bank_m[c] = (c == 5) ? ones : 64'h0;
    load_bank();
    set_lanes_all(16'd300);
    start_search(1'b0, 4'd0, 64'h0);
    check("first busy", 64'(busy), 64'd1);
    wait_result("first", 5, 0, -1, 1'b1);
    busy_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy === 1'b1) busy_seen++;
    end
    check("hold no_retrigger", 64'(busy_seen), 64'd0);
    check("hold result_valid", 64'(result_valid), 64'd1);

    // Table vectors
    for (int v = 0; v < 6; v++) begin
      for (int c = 0; c < 16; c++) bank_m[c] = (c == tbl[v].hot_idx) ? tbl[v].hot_val : tbl[v].other_val;
      load_bank();
      set_lanes_all(tbl[v].lane_val);
      start_search(1'b0, 4'd0, 64'h0);
      wait_result($sformatf("tbl%0d", v), tbl[v].exp_idx, tbl[v].exp_dist, -1, 1'b1);
    end

    // Tie: classes 3 and 9 equally near; lowest index wins
    for (int c = 0; c < 16; c++) bank_m[c] = ones;
    bank_m[3] = 64'h1; bank_m[9] = 64'h1;
    load_bank();
    set_lanes_all(16'd256);
    start_search(1'b0, 4'd0, 64'h0);
    wait_result("tie", 3, 1, 0, 1'b1);

    // Write during SEARCH is dropped, in this and the following search
    for (int c = 0; c < 16; c++) bank_m[c] = 64'h0;
    bank_m[10] = ones ^ 64'h8;
    load_bank();
    set_lanes_all(16'd300);
    start_search(1'b0, 4'd0, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    write_class(4'd2, ones);
    wait_result("busy_write", 10, 1, 63, 1'b0);
    start_search(1'b0, 4'd0, 64'h0);
    wait_result("after_busy_write", 10, 1, 63, 1'b1);

    // Write on the trigger edge is seen by that search
    bank_m[0] = ones;
    start_search(1'b1, 4'd0, ones);
    wait_result("same_edge_write", 0, 0, 1, 1'b1);

    // Reset mid-SEARCH aborts, then a fresh edge gives a full search
    start_search(1'b0, 4'd0, 64'h0);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1; enc_done = 1'b0;
    @(posedge clk); #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort result_valid", 64'(result_valid), 64'd0);
    check("abort class_idx", 64'(class_idx), 64'd0);
    check("abort min_dist", 64'(min_dist), 64'd0);
    reset = 1'b0;
    model(bi, bd, sd);
    start_search(1'b0, 4'd0, 64'h0);
    wait_result("post_abort", bi, bd, sd, 1'b1);

`ifdef HV_SIM_MARGIN_EN
    for (int c = 0; c < 16; c++) bank_m[c] = 64'h0;
    bank_m[4] = ones; bank_m[6] = ones ^ 64'hF000;
    load_bank();
    set_lanes_all(16'd300);
    start_search(1'b0, 4'd0, 64'h0);
    wait_result("margin4", 4, 0, 4, 1'b1);
    bank_m[6] = 64'h0; bank_m[11] = ones;
    write_class(4'd6, 64'h0);
    write_class(4'd11, ones);
    start_search(1'b0, 4'd0, 64'h0);
    wait_result("margin0", 4, 0, 0, 1'b1);
`endif

    // Random stimulus against the model, with occasional duplicated classes
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 16; c++) bank_m[c] = {$urandom, $urandom};
      if (r % 2 == 0) bank_m[$urandom_range(8, 15)] = bank_m[$urandom_range(0, 7)];
      load_bank();
      for (int i = 0; i < 64; i++) m_lanes[i] = 16'($urandom_range(0, 520));
      model(bi, bd, sd);
      start_search(1'b0, 4'd0, 64'h0);
      wait_result($sformatf("rand%0d", r), bi, bd, sd, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
